// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared state encoding and word width for the Hack boot loader
package hack_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    RUN     = 3'd4,
    ERROR   = 3'd5,
    CHK_HI  = 3'd6,
    CHK_LO  = 3'd7
  } state_t;

endpackage

// File: rtl/hack_boot_loader_if.sv
// rtl/hack_boot_loader_if.sv - host byte stream, ROM write port and CPU control bundle
interface hack_boot_loader_if #(parameter int ADDR_W = 15);

  logic                       rx_valid;
  logic [7:0]                 rx_data;
  logic                       rx_ready;
  logic                       reload;
  logic                       rom_we;
  logic [ADDR_W-1:0]          rom_addr;
  logic [hack_pkg::WORD_W-1:0] rom_wdata;
  logic                       cpu_reset;
  logic                       done;
  logic                       error;

  modport master (
    output rx_valid, rx_data, reload,
    input  rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, done, error
  );

  modport slave (
    input  rx_valid, rx_data, reload,
    output rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, done, error
  );

endinterface

// File: rtl/hack_word_asm.sv
// rtl/hack_word_asm.sv - pairs accepted bytes into big-endian words, pulsing on each lo byte
module hack_word_asm
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic       lo_phase;
  logic [7:0] hi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_phase <= 1'b0;
      hi_q     <= 8'h00;
    end else if (byte_valid) begin
      lo_phase <= ~lo_phase;
      if (!lo_phase) hi_q <= byte_data;
    end
  end

  // The word is presented combinationally alongside the lo byte so the FSM can act on it at once.
  assign word_valid = byte_valid & lo_phase;
  assign word       = {hi_q, byte_data};

endmodule

// File: rtl/hack_boot_loader.sv
// rtl/hack_boot_loader.sv - fills Hack instruction ROM from a byte stream, then releases the CPU; HACK_BOOT_CHECKSUM_EN adds a trailing checksum field
module hack_boot_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  hack_boot_loader_if.slave bus
);

  localparam int CW = ADDR_W + 1;
`ifdef HACK_BOOT_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHK_HI;
`else
  localparam state_t AFTER_DATA = RUN;
`endif

  state_t            state_q, state_d;
  logic [WORD_W-1:0] n_q;
  logic [CW-1:0]     cnt_q;
  logic              rom_we_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [WORD_W-1:0] rom_wdata_q;
  logic              cpu_reset_q;
  logic              loading, accept, word_valid;
  logic [WORD_W-1:0] word;
  logic              n_load, cnt_clr, wr;
`ifdef HACK_BOOT_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q;
`endif

  assign loading = (state_q != RUN) && (state_q != ERROR);
  assign accept  = bus.rx_valid & bus.rx_ready;

  hack_word_asm u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (accept),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d = state_q;
    n_load  = 1'b0;
    cnt_clr = 1'b0;
    wr      = 1'b0;
    case (state_q)
      HDR_HI:  if (accept) state_d = HDR_LO;
      HDR_LO: if (word_valid) begin
        n_load  = 1'b1;
        cnt_clr = 1'b1;
        if (32'(word) > (32'd1 << ADDR_W)) state_d = ERROR;
        else if (word == '0)               state_d = AFTER_DATA;
        else                               state_d = DATA_HI;
      end
      DATA_HI: if (accept) state_d = DATA_LO;
      DATA_LO: if (word_valid) begin
        wr      = 1'b1;
        state_d = ((32'(cnt_q) + 32'd1) == 32'(n_q)) ? AFTER_DATA : DATA_HI;
      end
`ifdef HACK_BOOT_CHECKSUM_EN
      CHK_HI:  if (accept) state_d = CHK_LO;
      CHK_LO:  if (word_valid) state_d = (word == sum_q) ? RUN : ERROR;
`endif
      RUN, ERROR: if (bus.reload) begin
        state_d = HDR_HI;
        cnt_clr = 1'b1;
      end
      default: state_d = HDR_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR_HI;
      n_q         <= '0;
      cnt_q       <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      rom_we_q <= wr;
      // Released only once RUN has been held for a cycle, so the last ROM write lands first.
      cpu_reset_q <= !((state_q == RUN) && (state_d == RUN));
      if (n_load) n_q <= word;
      if (cnt_clr)  cnt_q <= '0;
      else if (wr)  cnt_q <= cnt_q + CW'(1);
      if (wr) begin
        rom_addr_q  <= cnt_q[ADDR_W-1:0];
        rom_wdata_q <= word;
      end
    end
  end

`ifdef HACK_BOOT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) sum_q <= '0;
    else if (wr)          sum_q <= sum_q + word;
  end
`endif

  assign bus.rx_ready  = loading & ~reset;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.done      = (state_q == RUN);
  assign bus.error     = (state_q == ERROR);

endmodule

// File: tb/tb_hack_boot_loader.sv
// tb/tb_hack_boot_loader.sv - directed scoreboard bench for hack_boot_loader (HACK_BOOT_CHECKSUM_EN adds checksum cases)
module tb_hack_boot_loader;

  localparam int ADDR_W = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [30:0] exp_q[$];
  logic [15:0] wq[$];
  logic [30:0] exp_item;

  hack_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  hack_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every ROM write must match the next queued expectation, in order.
  always @(negedge clk) begin
    if (!reset && bus.rom_we === 1'b1) begin
      exp_item = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      vectors++;
      assert ({bus.rom_addr, bus.rom_wdata} === exp_item)
      else begin
        miscompares++;
        $error("FAIL rom_write: observed addr %0h data %0h expected %0h", bus.rom_addr, bus.rom_wdata, exp_item);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    if (gap) begin
      bus.rx_valid = 1'b0;
      tick();
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
  endtask

  task automatic load(input bit gap, input logic [15:0] chk_off);
    logic [15:0] n;
    logic [15:0] sum;
    logic [15:0] w;
    n   = 16'(wq.size());
    sum = 16'h0000;
    send(n[15:8], gap);
    send(n[7:0], gap);
    for (int i = 0; i < wq.size(); i++) begin
      w = wq[i];
      sum = sum + w;
      exp_q.push_back({15'(i), w});
      send(w[15:8], gap);
      send(w[7:0], gap);
    end
`ifdef HACK_BOOT_CHECKSUM_EN
    sum = sum + chk_off;
    send(sum[15:8], gap);
    send(sum[7:0], gap);
`else
    sum = sum + chk_off;
`endif
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.reload   = 1'b0;

    tick();
    chk("rx_ready_in_reset", bus.rx_ready, 0);
    reset = 1'b0;
    #1;
    chk("reset_cpu_reset", bus.cpu_reset, 1);
    chk("reset_rom_we", bus.rom_we, 0);
    chk("reset_rom_addr", bus.rom_addr, 0);
    chk("reset_rom_wdata", bus.rom_wdata, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_error", bus.error, 0);
    chk("reset_rx_ready", bus.rx_ready, 1);

    wq = '{16'h0002, 16'hEC10, 16'h0000};
    load(1'b0, 16'h0000);
    chk("run_done", bus.done, 1);
    chk("run_cpu_reset_held", bus.cpu_reset, 1);
    chk("run_rx_ready", bus.rx_ready, 0);
    tick();
    chk("run_cpu_released", bus.cpu_reset, 0);
    chk("run_done_stays", bus.done, 1);
    chk("writes_drained_1", exp_q.size(), 0);

    bus.reload   = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    tick();
    bus.reload   = 1'b0;
    bus.rx_valid = 1'b0;
    chk("reload_cpu_reset", bus.cpu_reset, 1);
    chk("reload_done_clr", bus.done, 0);
    chk("reload_rx_ready", bus.rx_ready, 1);

    load(1'b1, 16'h0000);
    chk("gap_done", bus.done, 1);
    tick();
    tick();
    chk("gap_cpu_released", bus.cpu_reset, 0);
    chk("writes_drained_2", exp_q.size(), 0);

    pulse_reload();
    send(8'h80, 1'b0);
    send(8'h01, 1'b0);
    chk("hdr_big_error", bus.error, 1);
    chk("hdr_big_cpu_reset", bus.cpu_reset, 1);
    chk("hdr_big_done", bus.done, 0);
    chk("hdr_big_rx_ready", bus.rx_ready, 0);
    tick();
    tick();
    pulse_reload();
    chk("err_reload_error", bus.error, 0);
    chk("err_reload_rx_ready", bus.rx_ready, 1);

    send(8'h80, 1'b0);
    send(8'h00, 1'b0);
    chk("hdr_max_no_error", bus.error, 0);
    chk("hdr_max_rx_ready", bus.rx_ready, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;

    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    exp_q.push_back({15'd0, 16'h1234});
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    reset = 1'b1;
    tick();
    chk("midreset_rom_we", bus.rom_we, 0);
    chk("midreset_rom_addr", bus.rom_addr, 0);
    chk("midreset_rx_ready", bus.rx_ready, 0);
    reset = 1'b0;
    #1;
    chk("midreset_cpu_reset", bus.cpu_reset, 1);
    chk("midreset_rx_ready_after", bus.rx_ready, 1);
    wq = '{16'h1234};
    load(1'b0, 16'h0000);
    chk("fresh_done", bus.done, 1);
    tick();
    chk("writes_drained_3", exp_q.size(), 0);

    pulse_reload();
    wq = {};
    load(1'b0, 16'h0000);
    chk("empty_done", bus.done, 1);
    chk("empty_error", bus.error, 0);

`ifdef HACK_BOOT_CHECKSUM_EN
    pulse_reload();
    wq = '{16'h0001, 16'hFFFF};
    load(1'b0, 16'h0000);
    chk("csum_ok_done", bus.done, 1);
    tick();
    pulse_reload();
    load(1'b0, 16'h0001);
    chk("csum_bad_error", bus.error, 1);
    chk("csum_bad_done", bus.done, 0);
    tick();
    chk("csum_bad_cpu_reset", bus.cpu_reset, 1);
`endif

    tick();
    tick();
    chk("writes_drained_final", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
